// File: rtl/sram_read_block_buffer_if.sv
// SRAM1 read-return and AES block handshake bundle; master drives reads and ready, slave is the buffer.
// Single clock domain; no logic inside.
interface sram_read_block_buffer_if #(
    parameter int DATA_W = 128
);
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              rd_stall;
    logic              blk_valid;
    logic              blk_ready;
    logic [DATA_W-1:0] blk_data;

    modport master (
        output r_en, r_data, blk_ready,
        input  rd_stall, blk_valid, blk_data
    );

    modport slave (
        input  r_en, r_data, blk_ready,
        output rd_stall, blk_valid, blk_data
    );
endinterface

// File: rtl/sram_read_block_buffer.sv
// Purpose: capture SRAM1 read returns into a small FWFT FIFO feeding the AES core (BUF_BYTE_SWAP_EN reverses bytes at capture).
// Latency: r_en to blk_valid is READ_LAT+1 cycles minimum.
// Backpressure: rd_stall holds off new reads once stored plus in-flight blocks would fill the FIFO.
module sram_read_block_buffer #(
    parameter int READ_LAT = 1,
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 128,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_read_block_buffer_if.slave  bus,
    input  logic                     flush,
    output logic [CNT_W-1:0]         count,
    output logic                     ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam int SUM_W = 8;

    logic [READ_LAT-1:0] pipe_q, pipe_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic [DATA_W-1:0]   cap_dat;
    logic [SUM_W-1:0]    inflight;
    logic                push, pop, full, do_wr;

    always_comb begin
`ifdef BUF_BYTE_SWAP_EN
        cap_dat = '0;
        for (int i = 0; i < NB; i++) begin
            cap_dat[8*(NB-1-i) +: 8] = bus.r_data[8*i +: 8];
        end
`else
        cap_dat = bus.r_data;
`endif
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + SUM_W'(pipe_q[i]);
        end
    end

    assign push          = pipe_q[READ_LAT-1];
    assign full          = (cnt_q == CNT_W'(DEPTH));
    assign bus.blk_valid = (cnt_q != '0);
    assign bus.blk_data  = mem_q[rd_ptr_q];
    assign pop           = bus.blk_valid & bus.blk_ready;
    // A full FIFO can still accept when the head leaves on the same edge.
    assign do_wr         = push & (~full | pop);
    assign bus.rd_stall  = (SUM_W'(cnt_q) + inflight) >= SUM_W'(DEPTH);
    assign count         = cnt_q;
    assign ovf           = ovf_q;

    always_comb begin
        pipe_d   = (pipe_q << 1) | READ_LAT'(bus.r_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        if (flush) begin
            pipe_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (do_wr) begin
                mem_d[wr_ptr_q] = cap_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_sram_read_block_buffer.sv
// Directed bench for sram_read_block_buffer with READ_LAT=1, DEPTH=2.
module tb_sram_read_block_buffer;
    localparam int DW = 128;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] count;
    logic       ovf;
    int         total = 0;
    int         bad   = 0;

    localparam logic [DW-1:0] BLK_S = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [DW-1:0] BLK_A = 128'h11223344556677889900AABBCCDDEEFF;
    localparam logic [DW-1:0] BLK_B = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    localparam logic [DW-1:0] BLK_C = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    localparam logic [DW-1:0] BLK_D = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    localparam logic [DW-1:0] BLK_E = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
    localparam logic [DW-1:0] BLK_F = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam logic [DW-1:0] BLK_G = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [DW-1:0] JUNK  = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

    sram_read_block_buffer_if #(.DATA_W(DW)) bus ();

    sram_read_block_buffer #(
        .READ_LAT (1),
        .DEPTH    (2),
        .DATA_W   (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .flush (flush),
        .count (count),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] x);
        logic [DW-1:0] y;
`ifdef BUF_BYTE_SWAP_EN
        y = {<<8{x}};
`else
        y = x;
`endif
        return y;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the FIFO holding a then b with blk_ready low.
    task automatic fill2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.blk_ready = 1'b0;
        bus.r_en      = 1'b1;
        step();
        bus.r_data    = a;
        step();
        bus.r_en      = 1'b0;
        bus.r_data    = b;
        step();
        bus.r_data    = JUNK;
    endtask

    initial begin
        logic [DW-1:0] swp;
        bus.r_en      = 1'b0;
        bus.r_data    = '0;
        bus.blk_ready = 1'b0;

        // reset
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_valid", DW'(bus.blk_valid), '0);
        check("rst_count", DW'(count), '0);
        check("rst_stall", DW'(bus.rd_stall), '0);
        check("rst_ovf",   DW'(ovf), '0);
        check("rst_data",  bus.blk_data, '0);

        // single read
        bus.blk_ready = 1'b1;
        bus.r_en      = 1'b1;
        step();
        bus.r_en      = 1'b0;
        bus.r_data    = BLK_S;
        check("single_early_valid", DW'(bus.blk_valid), '0);
        check("single_stall_inflight", DW'(bus.rd_stall), '0);
        step();
        bus.r_data = JUNK;
`ifdef BUF_BYTE_SWAP_EN
        swp = 128'h0F0E0D0C0B0A09080706050403020100;
`else
        swp = 128'h000102030405060708090A0B0C0D0E0F;
`endif
        check("single_valid", DW'(bus.blk_valid), 1);
        check("single_data",  bus.blk_data, swp);
        check("single_count1", DW'(count), 1);
        step();
        check("single_count0", DW'(count), '0);
        check("single_valid0", DW'(bus.blk_valid), '0);

        // back-pressure, then forced read into full FIFO with a pop on the same edge
        bus.blk_ready = 1'b0;
        bus.r_en      = 1'b1;
        check("bp_stall0", DW'(bus.rd_stall), '0);
        step();
        check("bp_stall1", DW'(bus.rd_stall), '0);
        bus.r_data = BLK_A;
        step();
        check("bp_stall2", DW'(bus.rd_stall), 1);
        bus.r_en   = 1'b0;
        bus.r_data = BLK_B;
        step();
        bus.r_data = JUNK;
        check("bp_count", DW'(count), 2);
        check("bp_head",  bus.blk_data, stored(BLK_A));
        check("bp_stall3", DW'(bus.rd_stall), 1);
        bus.r_en = 1'b1;
        step();
        bus.r_en      = 1'b0;
        bus.r_data    = BLK_C;
        bus.blk_ready = 1'b1;
        check("pp_head_a", bus.blk_data, stored(BLK_A));
        step();
        bus.r_data = JUNK;
        check("pp_count", DW'(count), 2);
        check("pp_head_b", bus.blk_data, stored(BLK_B));
        check("pp_ovf", DW'(ovf), '0);
        step();
        check("pp_head_c", bus.blk_data, stored(BLK_C));
        check("pp_count1", DW'(count), 1);
        step();
        check("pp_empty", DW'(bus.blk_valid), '0);

        // overflow
        fill2(BLK_A, BLK_B);
        check("ov_full", DW'(count), 2);
        bus.r_en = 1'b1;
        step();
        bus.r_en   = 1'b0;
        bus.r_data = BLK_D;
        step();
        bus.r_data = JUNK;
        check("ov_set",   DW'(ovf), 1);
        check("ov_count", DW'(count), 2);
        check("ov_head_a", bus.blk_data, stored(BLK_A));
        step();
        check("ov_sticky", DW'(ovf), 1);
        bus.blk_ready = 1'b1;
        step();
        check("ov_head_b", bus.blk_data, stored(BLK_B));
        step();
        check("ov_drained", DW'(count), '0);
        check("ov_sticky2", DW'(ovf), 1);

        // flush with one stored entry and one read in flight
        bus.blk_ready = 1'b0;
        bus.r_en      = 1'b1;
        step();
        bus.r_data = BLK_E;
        step();
        bus.r_en   = 1'b0;
        bus.r_data = BLK_F;
        check("fl_pre_count", DW'(count), 1);
        check("fl_pre_stall", DW'(bus.rd_stall), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_count", DW'(count), '0);
        check("fl_valid", DW'(bus.blk_valid), '0);
        check("fl_stall", DW'(bus.rd_stall), '0);
        check("fl_ovf_kept", DW'(ovf), 1);
        step();
        check("fl_no_late", DW'(count), '0);

        // read after flush lands at the reset pointer position
        bus.blk_ready = 1'b1;
        bus.r_en      = 1'b1;
        step();
        bus.r_en   = 1'b0;
        bus.r_data = BLK_G;
        step();
        bus.r_data = JUNK;
        check("post_fl_data", bus.blk_data, stored(BLK_G));
        step();

        // reset with a read in flight abandons the return
        bus.r_en = 1'b1;
        step();
        bus.r_en = 1'b0;
        rst      = 1'b1;
        #1;
        check("arst_ovf", DW'(ovf), '0);
        rst        = 1'b0;
        bus.r_data = BLK_A;
        step();
        check("arst_no_cap", DW'(bus.blk_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
